// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver/CPU-side signal bundle for the UART receive FIFO
interface uart_rx_fifo_if #(parameter int AW = 3);
  logic [7:0]  rx_data;
  logic        rx_status;
  logic        rd_en;
  logic        ovr_clr;
  logic [7:0]  rd_data;
  logic        empty;
  logic        full;
  logic [AW:0] count;
  logic        overrun;
  logic        irq;
  modport master(output rx_data, rx_status, rd_en, ovr_clr,
                 input rd_data, empty, full, count, overrun, irq);
  modport slave(input rx_data, rx_status, rd_en, ovr_clr,
                output rd_data, empty, full, count, overrun, irq);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: edge-captured UART receive bytes into a FWFT FIFO with overrun flag
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input logic           sysclk,
  input logic           reset,
  uart_rx_fifo_if.slave bus
);
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovr_q, ovr_d, st_q;
  logic          push, pop, wr, drop, empty, full;
  assign empty = cnt_q == '0;
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign push  = bus.rx_status & ~st_q;
  assign pop   = bus.rd_en & ~empty;
  assign wr    = push & (~full | pop);
  assign drop  = push & full & ~pop;
  always_comb begin
    wp_d  = wp_q + AW'(wr);
    rp_d  = rp_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(wr) - (AW+1)'(pop);
    ovr_d = drop | (ovr_q & ~bus.ovr_clr);
  end
  // st_q resets high so a completion level already present at release is ignored
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovr_q <= 1'b0;
      st_q  <= 1'b1;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      ovr_q <= ovr_d;
      st_q  <= bus.rx_status;
    end
  end
  always_ff @(posedge sysclk) begin
    if (wr) mem_q[wp_q] <= bus.rx_data;
  end
  assign bus.rd_data = mem_q[rp_q];
  assign bus.empty   = empty;
  assign bus.full    = full;
  assign bus.count   = cnt_q;
  assign bus.overrun = ovr_q;
  assign bus.irq     = ~empty;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: randomized and directed scoreboard check of uart_rx_fifo
module tb_uart_rx_fifo;
  localparam int DEPTH = 8;
  logic sysclk = 0;
  logic reset  = 1;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [7:0] mq[$];
  logic [7:0] sb[$];
  logic       m_ovr  = 0;
  logic       m_prev = 1;
  uart_rx_fifo_if #(.AW(3)) bus();
  uart_rx_fifo #(.DEPTH(DEPTH), .AW(3)) dut(.sysclk(sysclk), .reset(reset), .bus(bus));
  always #5 sysclk = ~sysclk;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // reference model: queue of accepted bytes, updated from inputs seen at each edge
  always @(posedge sysclk) begin
    if (reset) begin
      mq.delete();
      m_ovr  = 0;
      m_prev = 1;
    end else begin
      logic rise, pp, setov;
      rise  = bus.rx_status && !m_prev;
      pp    = bus.rd_en && mq.size() > 0;
      setov = rise && mq.size() == DEPTH && !pp;
      if (pp) void'(mq.pop_front());
      if (rise && mq.size() < DEPTH) begin
        mq.push_back(bus.rx_data);
        sb.push_back(bus.rx_data);
      end
      m_ovr  = setov ? 1'b1 : (bus.ovr_clr ? 1'b0 : m_ovr);
      m_prev = bus.rx_status;
    end
  end
  // monitor: status every cycle, and data whenever the DUT is about to pop
  always @(negedge sysclk) begin
    chk("count", int'(bus.count), mq.size());
    chk("empty", int'(bus.empty), int'(mq.size() == 0));
    chk("full", int'(bus.full), int'(mq.size() == DEPTH));
    chk("irq", int'(bus.irq), int'(mq.size() != 0));
    chk("overrun", int'(bus.overrun), int'(m_ovr));
    if (!reset && bus.rd_en && !bus.empty) begin
      if (sb.size() == 0) chk("rd_data_unexpected", int'(bus.rd_data), -1);
      else chk("rd_data", int'(bus.rd_data), int'(sb.pop_front()));
    end
  end
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask
  task automatic push_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_status = 1;
    cyc();
    bus.rx_status = 0;
    cyc();
  endtask
  task automatic pop_n(input int n);
    bus.rd_en = 1;
    cyc(n);
    bus.rd_en = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    bus.rx_data = 0; bus.rx_status = 0; bus.rd_en = 0; bus.ovr_clr = 0;
    cyc(3);
    chk("reset_empty", int'(bus.empty), 1);
    chk("reset_count", int'(bus.count), 0);
    reset = 0;
    cyc();
    bus.rx_data = 8'hA5; bus.rx_status = 1;
    cyc(40);
    bus.rx_status = 0;
    cyc();
    chk("single_count", int'(bus.count), 1);
    chk("single_data", int'(bus.rd_data), 8'hA5);
    chk("single_irq", int'(bus.irq), 1);
    pop_n(1);
    chk("single_popped", int'(bus.empty), 1);
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    chk("full_at_8", int'(bus.full), 1);
    pop_n(5);
    for (int i = 9; i <= 13; i++) push_byte(8'(i));
    pop_n(8);
    chk("wrap_drained", int'(bus.count), 0);
    for (int i = 0; i < 8; i++) push_byte(8'h30 + 8'(i));
    push_byte(8'hEE);
    chk("ovr_set", int'(bus.overrun), 1);
    chk("ovr_count", int'(bus.count), 8);
    bus.ovr_clr = 1; cyc(); bus.ovr_clr = 0;
    chk("ovr_cleared", int'(bus.overrun), 0);
    bus.rx_data = 8'hEF; bus.rx_status = 1; bus.ovr_clr = 1;
    cyc();
    bus.rx_status = 0; bus.ovr_clr = 0;
    cyc();
    chk("ovr_set_wins", int'(bus.overrun), 1);
    bus.ovr_clr = 1; cyc(); bus.ovr_clr = 0;
    bus.rx_data = 8'h55; bus.rx_status = 1; bus.rd_en = 1;
    cyc();
    bus.rx_status = 0; bus.rd_en = 0;
    cyc();
    chk("full_pushpop_count", int'(bus.count), 8);
    chk("full_pushpop_ovr", int'(bus.overrun), 0);
    pop_n(8);
    bus.rx_data = 8'h66; bus.rx_status = 1; bus.rd_en = 1;
    cyc();
    bus.rx_status = 0; bus.rd_en = 0;
    chk("empty_pushrd_count", int'(bus.count), 1);
    pop_n(1);
    pop_n(10);
    chk("empty_rd_count", int'(bus.count), 0);
    push_byte(8'h99);
    chk("after_empty_rd", int'(bus.rd_data), 8'h99);
    pop_n(1);
    for (int i = 0; i < 3; i++) push_byte(8'hC0 + 8'(i));
    bus.rx_data = 8'h77; bus.rx_status = 1;
    cyc();
    #2 reset = 1;
    mq.delete(); sb.delete(); m_ovr = 0; m_prev = 1;
    #1;
    chk("async_rst_count", int'(bus.count), 0);
    chk("async_rst_empty", int'(bus.empty), 1);
    chk("async_rst_irq", int'(bus.irq), 0);
    cyc();
    reset = 0;
    cyc(4);
    chk("no_capture_after_rst", int'(bus.count), 0);
    bus.rx_status = 0;
    cyc();
    push_byte(8'h42);
    chk("capture_after_fall", int'(bus.rd_data), 8'h42);
    pop_n(1);
    for (int i = 0; i < 3000; i++) begin
      bus.rx_status = ($urandom_range(0, 2) == 0);
      if (!bus.rx_status) bus.rx_data = 8'($urandom);
      bus.rd_en   = ($urandom_range(0, 3) == 0);
      bus.ovr_clr = ($urandom_range(0, 30) == 0);
      cyc();
    end
    bus.rx_status = 0; bus.ovr_clr = 0;
    pop_n(10);
    chk("final_drain", int'(bus.count), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
